// File: rtl/seven_segment_frame_decoder.sv
// Recovers displayed digits from a multiplexed, active-low seven-segment drive.
// Build option: SSD_HEX_DECODE_EN adds the A..F glyphs as codes 10..15.
module seven_segment_frame_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  Anode,
    input  logic [6:0]  LED_out,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic [3:0]  captured_mask,
    output logic        digit_err
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [3:0]  anode_q;
    logic [6:0]  led_q;
    logic [7:0]  cnt;
    logic [15:0] shadow;

    logic        changed;
    logic        blank;
    logic [7:0]  cnt_next;
    logic        hit;
    logic [3:0]  low;
    logic        one_hot;
    logic [4:0]  dec;
    logic        capture_ok;
    logic        err_set;
    logic [3:0]  mask_next;

    // Returns {valid, code}; valid=0 means the glyph is not a known digit.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
`ifdef SSD_HEX_DECODE_EN
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
`endif
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    always_comb begin
        changed  = (Anode != anode_q) || (LED_out != led_q);
        blank    = (Anode == 4'b1111);
        cnt_next = cnt;
        if (changed || blank)
            cnt_next = 8'd1;
        else if (cnt != STABLE)
            cnt_next = cnt + 8'd1;

        // A dwell fires only on the edge where the count arrives at STABLE,
        // so a long steady dwell captures once and never repeats.
        hit = (cnt_next == STABLE) && (changed || (cnt != STABLE)) && !blank;

        low     = ~Anode;
        one_hot = (low != 4'b0000) && ((low & (low - 4'd1)) == 4'b0000);
        dec     = decode(LED_out);

        capture_ok = hit && one_hot && dec[4];
        err_set    = hit && !(one_hot && dec[4]);

        mask_next = (captured_mask == 4'b1111) ? 4'b0000 : captured_mask;
        if (capture_ok)
            mask_next = mask_next | low;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anode_q       <= 4'b1111;
            led_q         <= 7'b1111111;
            cnt           <= 8'd0;
            shadow        <= 16'h0000;
            digits        <= 16'h0000;
            frame_valid   <= 1'b0;
            captured_mask <= 4'b0000;
            digit_err     <= 1'b0;
        end else begin
            anode_q       <= Anode;
            led_q         <= LED_out;
            cnt           <= cnt_next;
            captured_mask <= mask_next;
            frame_valid   <= 1'b0;
            // Publish the old shadow; a capture on this same edge belongs to the next frame.
            if (captured_mask == 4'b1111) begin
                digits      <= shadow;
                frame_valid <= 1'b1;
            end
            if (capture_ok) begin
                for (int i = 0; i < 4; i++)
                    if (low[i])
                        shadow[i*4 +: 4] <= dec[3:0];
            end
            if (err_set)
                digit_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_segment_frame_decoder.sv
// Bench for seven_segment_frame_decoder: directed scenarios plus random dwells
// compared each cycle against a dwell-level reference model.
module tb_seven_segment_frame_decoder;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  Anode;
    logic [6:0]  LED_out;
    logic [15:0] digits;
    logic        frame_valid;
    logic [3:0]  captured_mask;
    logic        digit_err;

    int total = 0;
    int bad   = 0;

    seven_segment_frame_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst(rst), .Anode(Anode), .LED_out(LED_out),
        .digits(digits), .frame_valid(frame_valid),
        .captured_mask(captured_mask), .digit_err(digit_err)
    );

    always #5 clk = ~clk;

    // Glyph table, index = code.
    logic [6:0] seg_tab [16];
    int         n_codes;

    // Reference model state: the current run of identical inputs and the frame in progress.
    logic [3:0]  prev_a;
    logic [6:0]  prev_l;
    int          run;
    logic [3:0]  m_slot [4];
    logic [3:0]  m_mask;
    logic [15:0] m_digits;
    logic        m_fv;
    logic        m_err;
    int          fv_count;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_decode(input logic [6:0] seg);
        for (int k = 0; k < n_codes; k++)
            if (seg_tab[k] == seg) return k;
        return -1;
    endfunction

    task automatic model_reset();
        prev_a = 4'b1111; prev_l = 7'h7F; run = 0;
        for (int k = 0; k < 4; k++) m_slot[k] = 4'h0;
        m_mask = 4'h0; m_digits = 16'h0; m_fv = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_outputs();
        check("frame_valid", {15'd0, frame_valid}, {15'd0, m_fv});
        check("captured_mask", {12'd0, captured_mask}, {12'd0, m_mask});
        check("digits", digits, m_digits);
        check("digit_err", {15'd0, digit_err}, {15'd0, m_err});
    endtask

    // One clock with the given inputs; the model applies the spec's rules for that edge.
    task automatic step(input logic [3:0] a, input logic [6:0] l);
        int zeros;
        int idx;
        int code;
        Anode = a; LED_out = l;
        @(posedge clk);
        if (a == prev_a && l == prev_l) run++; else run = 1;
        prev_a = a; prev_l = l;
        m_fv = 1'b0;
        if (m_mask == 4'hF) begin
            m_digits = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
            m_fv = 1'b1;
            m_mask = 4'h0;
        end
        if (run == STABLE && a != 4'b1111) begin
            zeros = 0; idx = 0;
            for (int k = 0; k < 4; k++) if (!a[k]) begin zeros++; idx = k; end
            code = m_decode(l);
            if (zeros == 1 && code >= 0) begin
                m_slot[idx] = 4'(code);
                m_mask[idx] = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        #1;
        if (frame_valid) fv_count++;
        check_outputs();
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] l, input int n);
        for (int k = 0; k < n; k++) step(a, l);
    endtask

    task automatic do_reset();
        rst = 1'b1; Anode = 4'b1111; LED_out = 7'h7F;
        @(posedge clk);
        model_reset();
        #1;
        check_outputs();
        rst = 1'b0;
    endtask

    task automatic scan(input int d0, input int d1, input int d2, input int d3);
        dwell(4'b1110, seg_tab[d0], 8);
        dwell(4'b1101, seg_tab[d1], 8);
        dwell(4'b1011, seg_tab[d2], 8);
        dwell(4'b0111, seg_tab[d3], 8);
        dwell(4'b1111, 7'h7F, 3);
    endtask

    initial begin
        logic [3:0] a;
        logic [6:0] l;
        int r;

        seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010;
        seg_tab[3]  = 7'b0000110; seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
        seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111; seg_tab[8]  = 7'b0000000;
        seg_tab[9]  = 7'b0000100; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
        seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010; seg_tab[14] = 7'b0110000;
        seg_tab[15] = 7'b0111000;
`ifdef SSD_HEX_DECODE_EN
        n_codes = 16;
`else
        n_codes = 10;
`endif
        fv_count = 0;
        model_reset();

        // Basic scan 1,2,3,4
        do_reset();
        fv_count = 0;
        scan(1, 2, 3, 4);
        check("scan_digits", digits, 16'h4321);
        check("scan_pulses", 16'(fv_count), 16'd1);
        check("scan_err", {15'd0, digit_err}, 16'd0);

        // Dwell one cycle short of STABLE
        do_reset();
        fv_count = 0;
        dwell(4'b1110, seg_tab[5], STABLE - 1);
        dwell(4'b1111, 7'h7F, 4);
        check("short_mask", {12'd0, captured_mask}, 16'd0);
        check("short_pulses", 16'(fv_count), 16'd0);

        // Two anodes low
        do_reset();
        dwell(4'b1110, seg_tab[3], 8);
        dwell(4'b1100, seg_tab[3], 3);
        check("multi_err_early", {15'd0, digit_err}, 16'd0);
        dwell(4'b1100, seg_tab[3], 5);
        check("multi_err", {15'd0, digit_err}, 16'd1);
        check("multi_mask", {12'd0, captured_mask}, 16'h1);
        scan(1, 1, 1, 1);
        check("multi_err_sticky", {15'd0, digit_err}, 16'd1);

        // Hex glyph on digit 0
        do_reset();
        dwell(4'b1110, 7'b0001000, 8);
`ifdef SSD_HEX_DECODE_EN
        check("hex_mask0", {15'd0, captured_mask[0]}, 16'd1);
        check("hex_err", {15'd0, digit_err}, 16'd0);
        dwell(4'b1101, seg_tab[1], 8);
        dwell(4'b1011, seg_tab[2], 8);
        dwell(4'b0111, seg_tab[3], 8);
        dwell(4'b1111, 7'h7F, 2);
        check("hex_digit0", {12'd0, digits[3:0]}, 16'hA);
`else
        check("hex_err", {15'd0, digit_err}, 16'd1);
        check("hex_mask0", {15'd0, captured_mask[0]}, 16'd0);
`endif

        // Reset mid-frame discards partial captures
        do_reset();
        dwell(4'b1110, seg_tab[0], 8);
        dwell(4'b1101, seg_tab[1], 8);
        dwell(4'b1011, seg_tab[2], 8);
        do_reset();
        check("rst_mask", {12'd0, captured_mask}, 16'd0);
        fv_count = 0;
        scan(5, 6, 7, 8);
        check("rst_digits", digits, 16'h8765);
        check("rst_pulses", 16'(fv_count), 16'd1);

        // Recapture: latest value wins
        do_reset();
        dwell(4'b1110, seg_tab[7], 8);
        dwell(4'b1111, 7'h7F, 2);
        dwell(4'b1110, seg_tab[9], 8);
        dwell(4'b1101, seg_tab[1], 8);
        dwell(4'b1011, seg_tab[1], 8);
        dwell(4'b0111, seg_tab[1], 8);
        dwell(4'b1111, 7'h7F, 2);
        check("recap_digit0", {12'd0, digits[3:0]}, 16'h9);
        check("recap_err", {15'd0, digit_err}, 16'd0);

        // Random dwells, including back-to-back captures across a frame boundary
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 19);
            if (r < 13) begin
                a = 4'b1111;
                a[$urandom_range(0, 3)] = 1'b0;
            end else if (r < 16) begin
                a = 4'b1111;
            end else begin
                a = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 9) < 8) l = seg_tab[$urandom_range(0, 15)];
            else l = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 59) == 0) do_reset();
            else dwell(a, l, $urandom_range(1, 8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_segment_frame_decoder.md
SEVEN_SEGMENT_FRAME_DECODER -- requirements
Module: seven_segment_frame_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, consecutive identical samples of Anode and LED_out required before a digit is captured (legal range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port Anode  input  4  digit select, active-low; Anode[i]=0 selects digit i.
REQ-005 SHALL have port LED_out  input  7  segments active-low, LED_out[6]=a .. LED_out[0]=g.
REQ-006 SHALL have port digits  output  16  last complete frame, {digit3,digit2,digit1,digit0}, one 4-bit code per digit.
REQ-007 SHALL have port frame_valid  output  1  one-cycle pulse when digits is updated.
REQ-008 SHALL have port captured_mask  output  4  digits captured in the frame in progress.
REQ-009 SHALL have port digit_err  output  1  sticky error flag.

Function
REQ-010 SHALL register Anode and LED_out once per cycle; stability counter increments (saturating at STABLE_CYCLES) while sample equals previous sample, else reloads to 1.
REQ-011 SHALL capture exactly once per dwell: in the cycle the counter first reaches STABLE_CYCLES with Anode one-hot-low; no further capture until Anode or LED_out changes.
REQ-012 SHALL decode patterns 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9 into the shadow slot for the selected digit and set its captured_mask bit.
REQ-013 SHALL treat Anode=1111 as blanking: no capture, no error, counter reloads.
REQ-014 SHALL, on a stable dwell with two or more Anode bits low, set digit_err and not capture.
REQ-015 SHALL, on a stable dwell with an undecodable pattern, set digit_err, leave slot and mask bit unchanged.
REQ-016 SHALL overwrite a slot whose mask bit is already set when it is recaptured (latest value wins), no error.
REQ-017 SHALL, in the cycle after captured_mask becomes 1111, copy shadow to digits, pulse frame_valid high for exactly one cycle, and clear captured_mask; latency from final capture edge to frame_valid is 1 cycle.
REQ-018 SHALL, if a capture coincides with the mask-clear cycle, apply the new capture to the next frame (mask bit set after clear).
REQ-019 SHALL keep digit_err set until rst; it never clears itself.
REQ-020 SHALL hold digits stable between frame_valid pulses.

Reset
REQ-021 SHALL, with rst high at a clock edge, set digits=16'h0000, frame_valid=0, captured_mask=4'b0000, digit_err=0, shadow slots=0, counter=0, sampled registers to Anode=1111/LED_out=1111111.
REQ-022 SHALL, on rst mid-frame, discard partial captures; first frame_valid after reset requires all four digits captured anew.

Configuration
REQ-023 SHALL honour macro SSD_HEX_DECODE_EN: when defined, additionally decode 0001000=A, 1100000=b, 0110001=C, 1000010=d, 0110000=E, 0111000=F as codes 10..15; when undefined, these patterns are undecodable per REQ-015.

Verification
REQ-024 SHALL test: reset, then scan digits 1,2,3,4 on Anode 1110,1101,1011,0111, 8 cycles each -> one frame_valid pulse, digits=16'h4321, digit_err=0.
REQ-025 SHALL test: Anode=1110 held 3 cycles with STABLE_CYCLES=4, then 1111 -> captured_mask stays 0000, no frame_valid.
REQ-026 SHALL test: Anode=1100 held 8 cycles -> digit_err=1 from the 4th sampled cycle, captured_mask unchanged, stays 1 until rst.
REQ-027 SHALL test: LED_out=0001000 on digit0 -> without SSD_HEX_DECODE_EN digit_err=1, mask bit0 clear; with it mask bit0 set and digits[3:0]=4'hA after frame.
REQ-028 SHALL test: capture digits 0-2, assert rst one cycle, scan full frame 5,6,7,8 -> single frame_valid, digits=16'h8765.
REQ-029 SHALL test: digit0 recaptured as 7 then 9 before frame completes -> frame digits[3:0]=4'h9, no error.
